bkg_map_ram: RTL and testbench
==============================

// Module: bkg_map_ram
// PURPOSE
//  Writable 20x15 tile map for the play field. On load_start it copies all 300 cells from
//  the background ROM (combinational addr->q), then serves one renderer read port and one
//  game-logic write port (bricks destroyed, bombs/fire placed). Sits between the ROM and the
//  VGA tile renderer / game FSM.
// PARAMETERS
//  MAP_W      20   tiles per row
//  MAP_H      15   rows
//  CELLS      300  MAP_W*MAP_H; cell index = row*MAP_W + col
//  TW         3    tile code width
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous, active-high reset
//  load_start  in   1   1-cycle pulse: begin ROM copy
//  rom_addr    out  9   address to background ROM
//  rom_q       in   3   ROM data, combinational from rom_addr
//  busy        out  1   high while copying
//  load_done   out  1   1-cycle pulse after last cell written
//  rd_addr     in   9   renderer read address
//  rd_q        out  3   registered read data, 1-cycle latency
//  wr_en       in   1   write request (single cycle)
//  wr_addr     in   9   write address
//  wr_data     in   3   tile code to write
//  wr_ack      out  1   pulse the cycle after a write is committed
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, rom_addr=0, busy=0, load_done=0, rd_q=0, wr_ack=0.
//    Map storage is not cleared by reset.
//  - FSM IDLE -> LOAD on load_start; LOAD -> RUN when cnt==CELLS-1 is written;
//    RUN -> LOAD on load_start (full reload). load_start while in LOAD ignored.
//  - LOAD: rom_addr=cnt; each cycle mem[cnt]<=rom_q, cnt++; exactly 300 cycles; busy=1
//    throughout; load_done pulses in the first RUN cycle; cnt returns to 0.
//  - Reads (RUN): rd_q <= mem[rd_addr] every cycle; rd_addr>=CELLS -> rd_q<=0.
//    In IDLE/LOAD rd_q<=0.
//  - Writes (RUN only): wr_en with wr_addr<CELLS commits mem[wr_addr]<=wr_data, wr_ack=1
//    next cycle. wr_addr>=CELLS or state!=RUN: dropped, wr_ack=0 (no queuing).
//  - Read/write same address same cycle: rd_q returns old value (read-before-write).
//  - Reset mid-LOAD: abort to IDLE; partially copied map undefined until next load.
// CONFIGURATION
//  PROTECT_WALL_EN defined: a write whose target cell currently holds TILE_WALL (1) is
//   dropped, wr_ack=0; walls are indestructible. ROM load still writes walls.
//  Not defined: all in-range writes commit regardless of current content.
// STRUCTURE
//  - Shared defs (bkg_defs.vh): MAP_W, MAP_H, CELLS, TILE_EMPTY=0, TILE_WALL=1,
//    TILE_BRICK=2, TILE_BOMB=3, TILE_FIRE=4, FSM state encodings.
//  - One sub-module: tile_ram_1r1w (CELLS x TW, registered read, one write port);
//    write-port mux between loader and game writer lives in bkg_map_ram.
// TESTING
//  1 rst, load_start -> busy=1 for 300 cycles, rom_addr 0..299, load_done 1 pulse, busy=0.
//  2 after load rd_addr=0/21/38 -> rd_q=1/0/1 one cycle later; rd_addr=300 -> rd_q=0.
//  3 wr_en addr=21 data=2 -> wr_ack next cycle; rd_addr=21 -> rd_q=2.
//  4 same cycle wr addr=23 data=3 and rd addr=23 -> rd_q=0, next read -> 3.
//  5 wr addr=0 data=0: PROTECT_WALL_EN -> wr_ack=0, rd=1; else wr_ack=1, rd=0.
//  6 rst at load cnt=150 -> busy=0 next cycle; new load_start -> full 300-cycle copy, map=ROM.

Source files
------------

// File: rtl/bkg_map_ram_pkg.sv
// rtl/bkg_map_ram_pkg.sv - shared map geometry, tile codes and FSM encodings
//
// Purpose: constants and types shared by bkg_map_ram and tile_ram_1r1w.
//   Map is MAP_W x MAP_H tiles, cell index = row*MAP_W + col.
// Ports: none (package).
package bkg_map_ram_pkg;

  localparam int MAP_W = 20;
  localparam int MAP_H = 15;
  localparam int CELLS = MAP_W * MAP_H;
  localparam int TW    = 3;
  localparam int AW    = 9;

  localparam logic [AW-1:0] CELLS_A   = AW'(CELLS);
  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);

  localparam logic [TW-1:0] TILE_EMPTY = 3'd0;
  localparam logic [TW-1:0] TILE_WALL  = 3'd1;
  localparam logic [TW-1:0] TILE_BRICK = 3'd2;
  localparam logic [TW-1:0] TILE_BOMB  = 3'd3;
  localparam logic [TW-1:0] TILE_FIRE  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } map_state_t;

  // True when a cell index addresses a real map cell.
  function automatic logic in_map(input logic [AW-1:0] a);
    return a < CELLS_A;
  endfunction

endpackage

// File: rtl/tile_ram_1r1w.sv
// rtl/tile_ram_1r1w.sv - CELLS x TW tile storage, one write port, one registered read port
//
// Purpose: backing store for the tile map. The registered read port returns
//   the value held before any same-cycle write (read-before-write). A
//   combinational peek port lets the owner inspect the cell being written.
//   Storage contents are not affected by reset; only rd_q is cleared.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset (rd_q only)
//   we         in   write enable
//   waddr      in   write cell index (caller guarantees < DEPTH when we=1)
//   wdata      in   tile code to store
//   rd_en      in   1: capture mem[raddr] into rd_q; 0: rd_q <= 0
//   raddr      in   read cell index
//   rd_q       out  registered read data
//   peek_addr  in   combinational inspect index
//   peek_q     out  mem[peek_addr], combinational
module tile_ram_1r1w
  import bkg_map_ram_pkg::*;
#(
  parameter int DEPTH = CELLS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [TW-1:0] wdata,
  input  logic          rd_en,
  input  logic [AW-1:0] raddr,
  output logic [TW-1:0] rd_q,
  input  logic [AW-1:0] peek_addr,
  output logic [TW-1:0] peek_q
);

  logic [TW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (rd_en) begin
      rd_q <= mem[raddr];
    end else begin
      rd_q <= '0;
    end
  end

  assign peek_q = mem[peek_addr];

endmodule

// File: rtl/bkg_map_ram.sv
// rtl/bkg_map_ram.sv - writable play-field tile map loaded from the background ROM
//
// Purpose: on load_start copies all CELLS tiles from the combinational
//   background ROM, then serves one renderer read port and one game-logic
//   write port. Build option PROTECT_WALL_EN: writes aimed at a cell that
//   currently holds TILE_WALL are dropped (the ROM load still writes walls).
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   load_start  in   1-cycle pulse, start (or restart from RUN) the ROM copy
//   rom_addr    out  ROM address (= copy counter)
//   rom_q       in   ROM data for rom_addr, combinational
//   busy        out  high during the copy
//   load_done   out  1-cycle pulse in the first RUN cycle
//   rd_addr     in   renderer read index
//   rd_q        out  tile code, 1-cycle latency, 0 outside RUN or out of range
//   wr_en       in   game write request
//   wr_addr     in   game write index
//   wr_data     in   tile code to write
//   wr_ack      out  pulses the cycle after a write commits
module bkg_map_ram
  import bkg_map_ram_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  output logic [AW-1:0] rom_addr,
  input  logic [TW-1:0] rom_q,
  output logic          busy,
  output logic          load_done,
  input  logic [AW-1:0] rd_addr,
  output logic [TW-1:0] rd_q,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [TW-1:0] wr_data,
  output logic          wr_ack
);

  map_state_t    state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic          load_done_nx;
  logic          game_wr;
  logic          wall_block;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [TW-1:0] mem_wdata;
  logic          rd_en;
  logic [TW-1:0] peek_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      load_done <= 1'b0;
      wr_ack    <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      load_done <= load_done_nx;
      wr_ack    <= game_wr;
    end
  end

  // Next state plus the write-port mux: the loader owns the RAM write port
  // in LOAD, the game writer owns it in RUN, nobody writes in IDLE.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    load_done_nx = 1'b0;
    busy         = 1'b0;
    game_wr      = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = wr_addr;
    mem_wdata    = wr_data;
    case (state)
      ST_IDLE: begin
        if (load_start) begin
          state_nx = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = cnt;
        mem_wdata = rom_q;
        if (cnt == LAST_CELL) begin
          state_nx     = ST_RUN;
          cnt_nx       = '0;
          load_done_nx = 1'b1;
        end else begin
          cnt_nx = cnt + AW'(1);
        end
      end
      ST_RUN: begin
        if (load_start) begin
          state_nx = ST_LOAD;
        end
        game_wr = wr_en && in_map(wr_addr) && !wall_block;
        mem_we  = game_wr;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign rom_addr = cnt;
  assign rd_en    = (state == ST_RUN) && in_map(rd_addr);

`ifdef PROTECT_WALL_EN
  assign wall_block = (peek_q == TILE_WALL);
`else
  logic unused_peek;
  assign wall_block  = 1'b0;
  assign unused_peek = ^peek_q;
`endif

  tile_ram_1r1w #(
    .DEPTH(CELLS)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .we       (mem_we),
    .waddr    (mem_waddr),
    .wdata    (mem_wdata),
    .rd_en    (rd_en),
    .raddr    (rd_addr),
    .rd_q     (rd_q),
    .peek_addr(wr_addr),
    .peek_q   (peek_q)
  );

endmodule

// File: tb/tb_bkg_map_ram.sv
// tb/tb_bkg_map_ram.sv - directed self-checking bench for bkg_map_ram
module tb_bkg_map_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start;
  logic [8:0] rom_addr;
  logic [2:0] rom_q;
  logic       busy;
  logic       load_done;
  logic [8:0] rd_addr;
  logic [2:0] rd_q;
  logic       wr_en;
  logic [8:0] wr_addr;
  logic [2:0] wr_data;
  logic       wr_ack;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bkg_map_ram dut (
    .clk       (clk),
    .rst       (rst),
    .load_start(load_start),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .busy      (busy),
    .load_done (load_done),
    .rd_addr   (rd_addr),
    .rd_q      (rd_q),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack)
  );

  // Background ROM: border walls, pillars at even row/even col, an extra
  // wall at row 1 col 18 (cell 38), scattered bricks/bombs/fire elsewhere.
  function automatic logic [2:0] rom_fn(input logic [8:0] a);
    int ai, r, c;
    ai = int'(a);
    r  = ai / 20;
    c  = ai % 20;
    if (ai >= 300) return 3'd0;
    if (r == 0 || r == 14 || c == 0 || c == 19) return 3'd1;
    if ((r % 2 == 0 && c % 2 == 0) || (r == 1 && c == 18)) return 3'd1;
    if (ai % 7 == 3) return 3'd2;
    if (ai % 13 == 6) return 3'd3;
    if (ai % 17 == 9) return 3'd4;
    return 3'd0;
  endfunction

  assign rom_q = rom_fn(rom_addr);

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int a, input int exp, input string tag);
    rd_addr = 9'(a);
    tick();
    check(tag, int'(rd_q), exp);
  endtask

  task automatic run_load(input string tag);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      check({tag, "_busy"}, int'(busy), 1);
      check({tag, "_rom_addr"}, int'(rom_addr), i);
      check({tag, "_done_early"}, int'(load_done), 0);
      // A load_start during LOAD must not restart the copy.
      load_start = (i == 100);
      tick();
      load_start = 1'b0;
    end
    check({tag, "_done_pulse"}, int'(load_done), 1);
    check({tag, "_busy_end"}, int'(busy), 0);
    tick();
    check({tag, "_done_clear"}, int'(load_done), 0);
  endtask

  task automatic check_map(input string tag);
    for (int i = 0; i < 300; i++) begin
      do_read(i, int'(rom_fn(9'(i))), tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    rd_addr    = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_busy", int'(busy), 0);
    check("rst_load_done", int'(load_done), 0);
    check("rst_rd_q", int'(rd_q), 0);
    check("rst_wr_ack", int'(wr_ack), 0);
    check("rst_rom_addr", int'(rom_addr), 0);

    // Write in IDLE is dropped.
    wr_en = 1'b1; wr_addr = 9'd5; wr_data = 3'd3;
    tick();
    wr_en = 1'b0;
    check("idle_wr_ack", int'(wr_ack), 0);
    do_read(5, 0, "idle_rd");

    // Test 1: full load.
    run_load("load1");

    // Test 2: reads.
    do_read(0, 1, "rd0");
    do_read(21, 0, "rd21");
    do_read(38, 1, "rd38");
    do_read(300, 0, "rd300");
    do_read(511, 0, "rd511");
    check_map("map1");

    // Test 3: write then read.
    wr_en = 1'b1; wr_addr = 9'd21; wr_data = 3'd2;
    tick();
    wr_en = 1'b0;
    check("wr21_ack", int'(wr_ack), 1);
    tick();
    check("wr21_ack_clear", int'(wr_ack), 0);
    do_read(21, 2, "rd21_after");

    // Test 4: read-before-write on the same cell.
    rd_addr = 9'd23;
    wr_en = 1'b1; wr_addr = 9'd23; wr_data = 3'd3;
    tick();
    wr_en = 1'b0;
    check("rbw_old", int'(rd_q), 0);
    check("rbw_ack", int'(wr_ack), 1);
    tick();
    check("rbw_new", int'(rd_q), 3);

    // Out-of-range write is dropped.
    wr_en = 1'b1; wr_addr = 9'd300; wr_data = 3'd4;
    tick();
    wr_en = 1'b0;
    check("wr300_ack", int'(wr_ack), 0);

    // Test 5: write over a wall.
    wr_en = 1'b1; wr_addr = 9'd0; wr_data = 3'd0;
    tick();
    wr_en = 1'b0;
`ifdef PROTECT_WALL_EN
    check("wall_ack", int'(wr_ack), 0);
    do_read(0, 1, "wall_rd");
`else
    check("wall_ack", int'(wr_ack), 1);
    do_read(0, 0, "wall_rd");
`endif

    // Test 6: reset in the middle of a reload, then a clean reload.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 150; i++) tick();
    check("mid_rom_addr", int'(rom_addr), 150);
    check("mid_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_rom_addr", int'(rom_addr), 0);
    do_read(0, 0, "abort_rd_idle");
    run_load("load2");
    do_read(21, 0, "rd21_reload");
    do_read(23, 0, "rd23_reload");
    do_read(0, 1, "rd0_reload");
    check_map("map2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
